jvn_cpu: RTL and testbench

Accumulator-based multicycle controller that drives the single-port 8-bit program/data memory as its sole master. It fetches instructions over the shared bidirectional data bus, executes them against an 8-bit accumulator, and writes results back through the same port. It is the stage directly upstream of the memory: it produces every `address`, `we` and write-`data` value the memory consumes, and it consumes the memory's read data.

---
 rtl/jvn_cpu_if.sv | 17 +
 rtl/jvn_cpu.sv | 136 +++++++++++++
 tb/tb_jvn_cpu.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jvn_cpu_if.sv
// ---------------------------------------------------------------------------
// jvn_cpu_if -- address/control half of the CPU-to-memory bus.
//
// The CPU is the only master of the memory, so it drives both signals.
//   we       master->slave  memory write enable
//   address  master->slave  memory address
//
// The 8-bit data bus is bidirectional and stays a plain inout net on the CPU.
// That keeps tristate resolution on ordinary module ports.
// ---------------------------------------------------------------------------
interface jvn_cpu_if;
    logic       we;
    logic [7:0] address;

    modport master (output we, output address);
    modport slave  (input  we, input  address);
endinterface

// File: rtl/jvn_cpu.sv
// ---------------------------------------------------------------------------
// jvn_cpu -- accumulator-based multicycle controller for a single-port 8-bit
// program/data memory.
//
// Every instruction takes two clocks: FETCH, then EXEC. HALT is terminal
// until reset.
//
// Instruction word:
//   ir[7]   = 1  JMP to {1'b0, ir[6:0]}
//   ir[7:4] = 0  NOP
//   ir[7:4] = 1  HALT
//   ir[7:4] = 2  NOP
//   ir[7:4] = 3  STORE
//   ir[7:4] = 4  LOAD
//   ir[7:4] = 5  ADD
//   ir[7:4] = 6  SUB
//   ir[7:4] = 7  AND
// Operand address is {DATA_PAGE, ir[3:0]}.
//
// Ports:
//   clock    in     system clock, rising edge
//   reset    in     asynchronous, active-high reset
//   mem_bus  master we / address toward the memory (jvn_cpu_if)
//   data     inout  shared data bus; driven with acc only while we = 1
//   acc      out    accumulator (observation)
//   pc       out    program counter (observation)
//   halted   out    high while in HALT
// ---------------------------------------------------------------------------
module jvn_cpu #(
    parameter logic [3:0] DATA_PAGE = 4'hF,
    parameter logic [7:0] RESET_PC  = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    jvn_cpu_if.master   mem_bus,
    inout  wire  [7:0]  data,
    output logic [7:0]  acc,
    output logic [7:0]  pc,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    // Only ir[6:4] is decoded.
    // These codes are used only when ir[7] = 0, so the MSB is implied.
    localparam logic [2:0] OP_HALT  = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd3;
    localparam logic [2:0] OP_LOAD  = 3'd4;
    localparam logic [2:0] OP_ADD   = 3'd5;
    localparam logic [2:0] OP_SUB   = 3'd6;
    localparam logic [2:0] OP_AND   = 3'd7;

    state_t     state_q;
    logic [7:0] pc_q;
    logic [7:0] ir_q;
    logic [7:0] acc_q;
    logic       halted_q;

    logic [7:0] acc_d;
    logic       we_d;
    logic [7:0] addr_d;

    // Bus control depends only on registered state, never on data.
    // Reset clears state_q asynchronously, so we_d drops the moment reset rises.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        we_d   = 1'b0;
        addr_d = pc_q;
        if (state_q == S_EXEC && !ir_q[7]) begin
            addr_d = {DATA_PAGE, ir_q[3:0]};
            we_d   = (ir_q[6:4] == OP_STORE);
        end
    end

    // The bus driver enable is exactly we.
    // The memory drives the bus only while we = 0.
    assign data = we_d ? acc_q : 8'hzz;

    // Accumulator next value in EXEC.
    // Opcodes that do not write acc keep it, and arithmetic wraps modulo 256.
    always_comb begin
        acc_d = acc_q;
        case (ir_q[6:4])
            OP_LOAD: acc_d = data;
            OP_ADD:  acc_d = acc_q + data;
            OP_SUB:  acc_d = acc_q - data;
            OP_AND:  acc_d = acc_q & data;
            default: acc_d = acc_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: state is assigned non-blocking so every register samples pre-edge values.
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= 8'h00;
            acc_q    <= 8'h00;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    ir_q    <= data;
                    pc_q    <= pc_q + 8'd1;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (ir_q[7]) begin
                        // The jump target overrides the pc already incremented in FETCH.
                        pc_q    <= {1'b0, ir_q[6:0]};
                        state_q <= S_FETCH;
                    end else if (ir_q[6:4] == OP_HALT) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        acc_q   <= acc_d;
                        state_q <= S_FETCH;
                    end
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign mem_bus.we      = we_d;
    assign mem_bus.address = addr_d;
    assign acc             = acc_q;
    assign pc              = pc_q;
    assign halted          = halted_q;

endmodule

// File: tb/tb_jvn_cpu.sv
// ---------------------------------------------------------------------------
// tb_jvn_cpu -- self-checking bench for jvn_cpu.
//
// The bench owns a 256-byte memory. That memory drives the data bus whenever
// we = 0 and commits writes at the clock edge.
//
// A separate instruction-level model executes one instruction per call:
//   - it holds its own memory image, acc, pc and halt flag;
//   - it predicts the bus values of each FETCH and EXEC cycle from the
//     instruction set rules.
// ---------------------------------------------------------------------------
module tb_jvn_cpu;

    localparam logic [3:0] PAGE = 4'hF;

    logic       clock;
    logic       reset;
    wire  [7:0] data;
    logic [7:0] acc;
    logic [7:0] pc;
    logic       halted;

    jvn_cpu_if bus ();

    logic [7:0] mem [256];

    // The memory answers combinationally and releases the bus while the CPU writes.
    assign data = bus.we ? 8'hzz : mem[bus.address];

    jvn_cpu #(.DATA_PAGE(PAGE), .RESET_PC(8'h00)) dut (
        .clock   (clock),
        .reset   (reset),
        .mem_bus (bus),
        .data    (data),
        .acc     (acc),
        .pc      (pc),
        .halted  (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction-level model state.
    logic [7:0] m_mem [256];
    logic [7:0] m_acc;
    logic [7:0] m_pc;
    logic       m_halt;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Called just before a posedge.
    // Samples the bus the edge sees, lets the edge happen, commits any write,
    // then returns at the following negedge.
    task automatic edge_commit();
        logic       s_we;
        logic [7:0] s_addr;
        logic [7:0] s_data;
        s_we   = bus.we;
        s_addr = bus.address;
        s_data = data;
        @(posedge clock);
        if (s_we) mem[s_addr] = s_data;
        @(negedge clock);
    endtask

    // Advance one clock, entering and leaving at a negedge.
    task automatic tick();
        #4;
        edge_commit();
    endtask

    task automatic model_reset();
        m_pc   = 8'h00;
        m_acc  = 8'h00;
        m_halt = 1'b0;
        foreach (mem[i]) m_mem[i] = mem[i];
    endtask

    // Entered at a negedge. Holds reset across a posedge, checks the reset
    // values, then releases reset so the next posedge ends the first FETCH.
    task automatic do_reset();
        #1 reset = 1'b1;
        #3;
        edge_commit();
        check("rst_we",     32'(bus.we),      32'(0));
        check("rst_addr",   32'(bus.address), 32'(8'h00));
        check("rst_data",   32'(data),        32'(mem[0]));
        check("rst_acc",    32'(acc),         32'(8'h00));
        check("rst_pc",     32'(pc),          32'(8'h00));
        check("rst_halted", 32'(halted),      32'(0));
        reset = 1'b0;
        model_reset();
    endtask

    // Runs one instruction: FETCH then EXEC.
    // Checks the bus in both cycles, and the registers once EXEC has ended.
    task automatic run_instr();
        logic [7:0] ir;
        logic [7:0] nxt_pc;
        logic [7:0] opnd_addr;
        logic [7:0] exp_addr;
        logic       exp_we;
        int a;
        int b;
        ir        = m_mem[m_pc];
        nxt_pc    = 8'((int'(m_pc) + 1) % 256);
        opnd_addr = {PAGE, ir[3:0]};

        check("f_we",   32'(bus.we),      32'(0));
        check("f_addr", 32'(bus.address), 32'(m_pc));
        check("f_data", 32'(data),        32'(m_mem[m_pc]));
        tick();

        exp_we   = (ir[7:4] == 4'h3);
        exp_addr = ir[7] ? nxt_pc : opnd_addr;
        check("e_we",     32'(bus.we),      32'(exp_we));
        check("e_addr",   32'(bus.address), 32'(exp_addr));
        check("e_data",   32'(data),        32'(exp_we ? m_acc : m_mem[exp_addr]));
        check("e_halted", 32'(halted),      32'(0));
        tick();

        a    = int'(m_acc);
        b    = int'(m_mem[opnd_addr]);
        m_pc = nxt_pc;
        if (ir[7]) begin
            m_pc = {1'b0, ir[6:0]};
        end else begin
            case (ir[7:4])
                4'h1: m_halt = 1'b1;
                4'h3: m_mem[opnd_addr] = m_acc;
                4'h4: m_acc = 8'(b);
                4'h5: m_acc = 8'((a + b) % 256);
                4'h6: m_acc = 8'((a - b + 256) % 256);
                4'h7: m_acc = 8'(a & b);
                default: ;
            endcase
        end
        check("pc",     32'(pc),     32'(m_pc));
        check("acc",    32'(acc),    32'(m_acc));
        check("halted", 32'(halted), 32'(m_halt));
    endtask

    task automatic halt_cycle();
        check("h_we",     32'(bus.we),      32'(0));
        check("h_addr",   32'(bus.address), 32'(m_pc));
        check("h_halted", 32'(halted),      32'(1));
        check("h_pc",     32'(pc),          32'(m_pc));
        tick();
    endtask

    task automatic clear_mem();
        foreach (mem[i]) mem[i] = 8'h00;
    endtask

    logic [7:0] fib_exp [5] = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd8};
    logic [7:0] fib_prog [8] = '{8'h40, 8'h51, 8'h32, 8'h41, 8'h30, 8'h42, 8'h31, 8'h80};
    logic [7:0] sub_prog [6] = '{8'h40, 8'h61, 8'h32, 8'h71, 8'h33, 8'h10};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clear_mem();
        @(negedge clock);

        // Fibonacci loop: 8 instructions, i.e. 16 clocks, per iteration.
        clear_mem();
        for (int i = 0; i < 8; i++) mem[i] = fib_prog[i];
        mem[240] = 8'd0;
        mem[241] = 8'd1;
        do_reset();
        for (int loop = 1; loop <= 13; loop++) begin
            for (int k = 0; k < 8; k++) run_instr();
            check("fib_model", 32'(mem[241]), 32'(m_mem[241]));
            if (loop <= 5) check("fib_val", 32'(mem[241]), 32'(fib_exp[loop-1]));
        end
        check("fib_wrap", 32'(mem[241]), 32'(8'd121));

        // SUB, AND and wrap-around.
        clear_mem();
        for (int i = 0; i < 6; i++) mem[i] = sub_prog[i];
        mem[240] = 8'h05;
        mem[241] = 8'h0F;
        do_reset();
        for (int k = 0; k < 6; k++) run_instr();
        check("sub_wrap", 32'(mem[242]), 32'(8'hF6));
        check("and_val",  32'(mem[243]), 32'(8'h06));

        // HALT: pc freezes, and the STORE after HALT never runs.
        clear_mem();
        mem[0]   = 8'h40;
        mem[1]   = 8'h10;
        mem[2]   = 8'h31;
        mem[240] = 8'h3C;
        mem[241] = 8'hA5;
        do_reset();
        run_instr();
        run_instr();
        check("halt_pc", 32'(pc), 32'(8'h02));
        for (int k = 0; k < 20; k++) halt_cycle();
        check("halt_mem", 32'(mem[241]), 32'(8'hA5));
        check("halt_acc", 32'(acc),      32'(8'h3C));

        // Reset asserted during EXEC of a STORE.
        clear_mem();
        mem[0]   = 8'h40;
        mem[1]   = 8'h31;
        mem[240] = 8'h5A;
        mem[241] = 8'h11;
        do_reset();
        run_instr();
        check("ms_f_we", 32'(bus.we), 32'(0));
        tick();
        check("ms_e_we",   32'(bus.we), 32'(1));
        check("ms_e_data", 32'(data),   32'(8'h5A));
        #1 reset = 1'b1;
        #1;
        check("ms_we_drop", 32'(bus.we),      32'(0));
        check("ms_addr",    32'(bus.address), 32'(8'h00));
        check("ms_data",    32'(data),        32'(mem[0]));
        #2;
        edge_commit();
        check("ms_no_write", 32'(mem[241]), 32'(8'h11));
        check("ms_pc",       32'(pc),       32'(8'h00));
        reset = 1'b0;
        model_reset();
        run_instr();
        check("ms_restart_acc", 32'(acc), 32'(8'h5A));

        // Random programs.
        // HALT is thinned out so most programs run their full budget.
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 256; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                if (b[7:4] == 4'h1 && $urandom_range(0, 7) != 0) b = 8'h00;
                mem[i] = b;
            end
            do_reset();
            for (int k = 0; k < 50 && !m_halt; k++) run_instr();
            for (int i = 240; i < 256; i++) check("rand_mem", 32'(mem[i]), 32'(m_mem[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
